// File: rtl/mem_store_rmw_pkg.sv
// Shared definitions for the store read-modify-write path: size codes,
// FSM states and small decode helpers.
package mem_store_rmw_pkg;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      WAIT  = 3'd2,
      WRITE = 3'd3,
      FIN   = 3'd4
   } state_t;

   // Size code 2'b11 behaves as a full-word store.
   function automatic logic [1:0] norm_size(input logic [1:0] s);
      return (s == 2'b11) ? SZ_WORD : s;
   endfunction

   function automatic logic misaligned(input logic [1:0] s, input logic [1:0] lo);
      return ((s == SZ_HALF) && lo[0]) || ((s == SZ_WORD) && (lo != 2'b00));
   endfunction

endpackage

// File: rtl/mem_store_rmw_store_lane_merge.sv
// Combinational little-endian lane merge: inserts a word, half or byte
// into an old memory word at the lanes selected by the low address bits.
module store_lane_merge
   import mem_store_rmw_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   input  logic [1:0]  size,
   input  logic [1:0]  lo,
   output logic [31:0] merged_c
);

   always_comb begin
      merged_c = old_word;
      case (size)
         SZ_HALF: begin
            if (lo[1]) merged_c[31:16] = wdata[15:0];
            else       merged_c[15:0]  = wdata[15:0];
         end
         SZ_BYTE: merged_c[{lo, 3'b000} +: 8] = wdata[7:0];
         default: merged_c = wdata;
      endcase
   end

endmodule

// File: rtl/mem_store_rmw.sv
// Store stage: full words are written directly, halves/bytes go through a
// read-modify-write. Optional misalignment trap: MEM_STORE_MISALIGN_CHECK_EN.
module mem_store_rmw
   import mem_store_rmw_pkg::*;
#(
   parameter int unsigned READ_LAT = 1,
   parameter int unsigned ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [1:0]        store_size,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   input  logic [31:0]       mem_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_wr,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int unsigned CNT_W = 2;

   state_t            state_q, state_d;
   logic [1:0]        size_q, size_d;
   logic [1:0]        lo_q, lo_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [31:0]       mem_wdata_d;
   logic [31:0]       merged_c;
   logic              mis_c;

`ifdef MEM_STORE_MISALIGN_CHECK_EN
   assign mis_c = misaligned(norm_size(store_size), addr[1:0]);

   // err is only ever high alongside the done pulse of a trapped request.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) err <= 1'b0;
      else          err <= (state_q == IDLE) && start && mis_c;
   end
`else
   assign mis_c = 1'b0;
   assign err   = 1'b0;
`endif

   store_lane_merge u_merge (
      .old_word (mem_rdata),
      .wdata    (wdata_q),
      .size     (size_q),
      .lo       (lo_q),
      .merged_c (merged_c)
   );

   // Next state and next register contents.
   always_comb begin
      state_d     = state_q;
      size_d      = size_q;
      lo_d        = lo_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      case (state_q)
         IDLE: begin
            if (start) begin
               size_d     = norm_size(store_size);
               lo_d       = addr[1:0];
               wdata_d    = wdata;
               mem_addr_d = {addr[ADDR_W-1:2], 2'b00};
               if (mis_c) begin
                  state_d = FIN;
               end else if (norm_size(store_size) == SZ_WORD) begin
                  mem_wdata_d = wdata;
                  state_d     = WRITE;
               end else begin
                  state_d = READ;
               end
            end
         end
         READ: begin
            cnt_d   = CNT_W'(READ_LAT - 1);
            state_d = WAIT;
         end
         WAIT: begin
            // Merge straight off the read data so mem_wdata is ready in WRITE.
            if (cnt_q == '0) begin
               mem_wdata_d = merged_c;
               state_d     = WRITE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         WRITE:   state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         size_q    <= SZ_WORD;
         lo_q      <= 2'b00;
         wdata_q   <= '0;
         cnt_q     <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wr    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         size_q    <= size_d;
         lo_q      <= lo_d;
         wdata_q   <= wdata_d;
         cnt_q     <= cnt_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         mem_wr    <= (state_d == WRITE);
         busy      <= (state_d == READ) || (state_d == WAIT) || (state_d == WRITE);
         done      <= (state_d == FIN);
      end
   end

endmodule

// File: tb/tb_mem_store_rmw.sv
// Randomized scoreboard bench for mem_store_rmw against a byte-array
// reference memory; honours MEM_STORE_MISALIGN_CHECK_EN when defined.
module tb_mem_store_rmw;

   localparam int unsigned LAT = 2;
`ifdef MEM_STORE_MISALIGN_CHECK_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   typedef struct {
      logic        wr;
      logic        err;
      logic [31:0] addr;
      logic [31:0] data;
      int          lat;
      int          start_cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  store_size = 2'b00;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] mem_rdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_wr, busy, done, err;

   logic [31:0] dmem [0:15];
   logic [7:0]  rbytes [0:63];
   logic [31:0] apipe [0:LAT-1];
   exp_t        q[$];
   bit          wr_seen = 1'b0;
   int          cyc = 0;
   int          tests = 0;
   int          fails = 0;

   mem_store_rmw #(.READ_LAT(LAT), .ADDR_W(32)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .store_size (store_size),
      .addr       (addr),
      .wdata      (wdata),
      .mem_rdata  (mem_rdata),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wr     (mem_wr),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory with a LAT-cycle read pipeline.
   always @(posedge clk) begin
      apipe[0] <= mem_addr;
      for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
      if (reset_n && mem_wr) dmem[mem_addr[5:2]] <= mem_wdata;
   end
   assign mem_rdata = dmem[apipe[LAT-1][5:2]];

   // Monitor: checks every write strobe and done pulse against the queue head.
   always @(negedge clk) begin
      exp_t e;
      if (reset_n) begin
         if (mem_wr) begin
            tests++;
            if (q.size() == 0 || !q[0].wr || wr_seen) begin
               fails++;
               $display("FAIL unexpected_write addr=%h data=%h", mem_addr, mem_wdata);
            end else if (mem_addr !== q[0].addr || mem_wdata !== q[0].data || busy !== 1'b1) begin
               fails++;
               $display("FAIL write got addr=%h data=%h busy=%b want addr=%h data=%h busy=1",
                        mem_addr, mem_wdata, busy, q[0].addr, q[0].data);
            end
            wr_seen = 1'b1;
         end
         if (done) begin
            tests++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
               e = q.pop_front();
               if ((cyc - e.start_cyc) != (e.lat - 1) || err !== e.err || wr_seen != e.wr ||
                   busy !== 1'b0 || (e.wr && mem_addr !== e.addr)) begin
                  fails++;
                  $display("FAIL done got lat=%0d err=%b wr=%b busy=%b addr=%h want lat=%0d err=%b wr=%b busy=0 addr=%h",
                           cyc - e.start_cyc + 1, err, wr_seen, busy, mem_addr,
                           e.lat, e.err, e.wr, e.addr);
               end
            end
            wr_seen = 1'b0;
         end
      end
   end

   task automatic junk(input bit s);
      start      = s;
      store_size = 2'($urandom);
      addr       = $urandom;
      wdata      = $urandom;
   endtask

   // Drive one request and push its expected outcome from the byte model.
   task automatic issue(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      int nb, base, wa;
      nb   = (sz == 2'b01) ? 2 : (sz == 2'b10) ? 1 : 4;
      base = int'(a) & ~(nb - 1);
      wa   = int'(a) & ~3;
      e.err  = MIS_EN && ((int'(a) % nb) != 0);
      e.wr   = !e.err;
      e.addr = 32'(wa);
      e.lat  = e.err ? 2 : (nb == 4) ? 3 : int'(LAT) + 4;
      if (e.wr)
         for (int i = 0; i < nb; i++) rbytes[base + i] = d[8*i +: 8];
      e.data = {rbytes[wa+3], rbytes[wa+2], rbytes[wa+1], rbytes[wa]};
      e.start_cyc = cyc;
      q.push_back(e);
      start = 1'b1; store_size = sz; addr = a; wdata = d;
   endtask

   task automatic run_op(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
      bit seen;
      seen = 1'b0;
      issue(sz, a, d);
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         else junk($urandom_range(0, 3) == 0);
      end
      if (!seen) begin
         tests++; fails++;
         $display("FAIL done_timeout sz=%0d addr=%h", sz, a);
         q.delete();
      end
      junk(1'b1);
      @(negedge clk);
      junk(1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      tests++;
      if (mem_addr !== '0 || mem_wdata !== '0 || mem_wr !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || err !== 1'b0) begin
         fails++;
         $display("FAIL %s got addr=%h wdata=%h wr=%b busy=%b done=%b err=%b want all 0",
                  tag, mem_addr, mem_wdata, mem_wr, busy, done, err);
      end
   endtask

   initial begin
      logic [31:0] v;
      for (int i = 0; i < LAT; i++) apipe[i] = '0;
      for (int w = 0; w < 16; w++) begin
         v = $urandom;
         if (w == 1) v = 32'hAAAABBBB;
         if (w == 8) v = 32'h11223344;
         dmem[w] = v;
         for (int b = 0; b < 4; b++) rbytes[4*w + b] = v[8*b +: 8];
      end
      repeat (3) @(negedge clk);
      check_zero("reset_state");
      reset_n = 1'b1;
      @(negedge clk);

      run_op(2'b00, 32'h10, 32'hDEADBEEF);
      run_op(2'b10, 32'h22, 32'h000000AB);
      run_op(2'b01, 32'h06, 32'h0000CAFE);
      run_op(2'b10, 32'h03, 32'h0000005A);
      run_op(2'b01, 32'h01, 32'h00001234);
      run_op(2'b00, 32'h0E, 32'h0BADF00D);
      run_op(2'b11, 32'h2D, 32'h76543210);

      // Reset during WAIT must abort without any write.
      start = 1'b1; store_size = 2'b01; addr = 32'h0A; wdata = 32'h0000BEEF;
      @(negedge clk); junk(1'b0);
      @(negedge clk);
      reset_n = 1'b0;
      #1 check_zero("reset_in_wait");
      repeat (2) @(negedge clk);
      check_zero("reset_held");
      reset_n = 1'b1;
      @(negedge clk);
      run_op(2'b00, 32'h30, 32'hFEEDFACE);

      for (int k = 0; k < 60; k++)
         run_op(2'($urandom), 32'($urandom_range(0, 63)), $urandom);

      repeat (4) @(negedge clk);
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain got %0d pending want 0", q.size());
      end
      for (int w = 0; w < 16; w++) begin
         tests++;
         v = {rbytes[4*w+3], rbytes[4*w+2], rbytes[4*w+1], rbytes[4*w]};
         if (dmem[w] !== v) begin
            fails++;
            $display("FAIL mem_word[%0d] got %h want %h", w, dmem[w], v);
         end
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
